// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: paces convst/busy conversions inside each
// adc_en window, tags samples and queues them on a valid/ready stream.
// Ports: fpga_clk/sys_rst; adc_en, rf_sw, rot_count from the scan FSM;
// adc_busy/adc_data/adc_convst to the ADC; out_data/out_valid/out_ready
// downstream; fifo_level, win_done, sticky overflow/timeout/sel_err.
module adc_capture_ctrl #(
  parameter int ADC_W      = 12,
  parameter int CLK_DIV    = 100,
  parameter int BUSY_TMO   = 64,
  parameter int MAX_SAMP   = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          fpga_clk,
  input  logic                          sys_rst,
  input  logic                          adc_en,
  input  logic [3:0]                    rf_sw,
  input  logic [9:0]                    rot_count,
  input  logic                          err_clr,
  input  logic                          adc_busy,
  input  logic [ADC_W-1:0]              adc_data,
  output logic                          adc_convst,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          win_done,
  output logic                          overflow,
  output logic                          timeout,
  output logic                          sel_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(CLK_DIV + BUSY_TMO + 4);
  localparam int TW = $clog2(BUSY_TMO + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] LATCH     = 3'd3;
  localparam logic [2:0] PACE      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  logic [2:0]    state, state_nx;
  logic          en_q;
  logic [9:0]    rot_q;
  logic [1:0]    ch_q, ch_dec;
  logic [8:0]    idx_q;
  logic [7:0]    idx_tag;
  logic [PW-1:0] pace_cnt;
  logic [TW-1:0] wait_cnt;
  logic [11:0]   samp12;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic en_rise, sel_bad, busy_ok, tmo_hit, pace_end, more;
  logic full, push, pop, drop, sel_ev;

  // en_q resets high so a level already present at reset release
  // is not taken as a window start.
  assign en_rise  = adc_en & ~en_q;
  assign busy_ok  = ~adc_busy && (wait_cnt != '0);
  assign tmo_hit  = (state == WAIT_BUSY) && !busy_ok &&
                    (wait_cnt == TW'(BUSY_TMO - 1));
  // >= so a timeout longer than the pace period still terminates
  assign pace_end = pace_cnt >= PW'(CLK_DIV - 1);
  assign more     = adc_en && (idx_q < 9'(MAX_SAMP));
  assign idx_tag  = idx_q[8] ? 8'hff : idx_q[7:0];
  assign samp12   = 12'(adc_data);

  assign full     = count == (AW+1)'(FIFO_DEPTH);
  assign push     = (state == LATCH) && !full;
  assign drop     = (state == LATCH) && full;
  assign pop      = out_valid && out_ready;
  assign sel_ev   = (state == IDLE) && en_rise && sel_bad;

  assign adc_convst = state == START;
  assign win_done   = state == DONE;
  assign out_valid  = count != '0;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = count;

  always_comb begin
    ch_dec  = 2'd0;
    sel_bad = 1'b0;
    case (rf_sw)
      4'b0001: ch_dec = 2'd0;
      4'b0010: ch_dec = 2'd1;
      4'b0100: ch_dec = 2'd2;
      4'b1000: ch_dec = 2'd3;
      default: sel_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (en_rise) state_nx = sel_bad ? DONE : START;
      START:
        state_nx = WAIT_BUSY;
      WAIT_BUSY:
        if (busy_ok)      state_nx = LATCH;
        else if (tmo_hit) state_nx = PACE;
      LATCH:
        state_nx = PACE;
      PACE:
        if (pace_end) state_nx = more ? START : DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      en_q     <= 1'b1;
      rot_q    <= '0;
      ch_q     <= '0;
      idx_q    <= '0;
      pace_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      en_q  <= adc_en;
      if (state == IDLE && en_rise) begin
        rot_q <= rot_count;
        ch_q  <= ch_dec;
        idx_q <= '0;
      end
      // a slot consumes an index whether latched or timed out
      if ((state == LATCH || tmo_hit) && idx_q != 9'd256)
        idx_q <= idx_q + 9'd1;
      // zero on entry so pace_cnt reads 0 during START
      if (state_nx == START)
        pace_cnt <= '0;
      else if (state != IDLE)
        pace_cnt <= pace_cnt + PW'(1);
      if (state == START)
        wait_cnt <= '0;
      else if (state == WAIT_BUSY)
        wait_cnt <= wait_cnt + TW'(1);
    end
  end

  always_ff @(posedge fpga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (push) mem[wr_ptr] <= {rot_q, ch_q, idx_tag, samp12};
  end

  // an error event in the clear cycle keeps the flag set
  always_ff @(posedge fpga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (tmo_hit)      timeout  <= 1'b1;
      else if (err_clr) timeout  <= 1'b0;
      if (sel_ev)       sel_err  <= 1'b1;
      else if (err_clr) sel_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: ADC behavioural model, scoreboard queue of
// expected words and a negedge monitor that pops on each accepted word.
module tb_adc_capture_ctrl;

  logic        fpga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        adc_en = 1'b0;
  logic [3:0]  rf_sw = 4'b0;
  logic [9:0]  rot_count = 10'd0;
  logic        err_clr = 1'b0;
  logic        adc_busy = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic        adc_convst;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic        win_done;
  logic        overflow;
  logic        timeout;
  logic        sel_err;

  adc_capture_ctrl dut (
    .fpga_clk   (fpga_clk),
    .sys_rst    (sys_rst),
    .adc_en     (adc_en),
    .rf_sw      (rf_sw),
    .rot_count  (rot_count),
    .err_clr    (err_clr),
    .adc_busy   (adc_busy),
    .adc_data   (adc_data),
    .adc_convst (adc_convst),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .win_done   (win_done),
    .overflow   (overflow),
    .timeout    (timeout),
    .sel_err    (sel_err)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int conv_cnt = 0;
  int win_cnt = 0;
  int last_cv = -1;
  int busy_len = 9;
  int stuck_conv = -1;
  int busy_left = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(int rot, int ch, int idx, int d);
    return {10'(rot), 2'(ch), 8'(idx), 12'(d)};
  endfunction

  always @(posedge fpga_clk) cyc++;

  // ADC model: busy rises after convst, falls busy_len negedges later
  always @(negedge fpga_clk) begin
    if (sys_rst) begin
      adc_busy = 1'b0;
      busy_left = 0;
    end else if (adc_convst) begin
      if (last_cv >= 0) chk("convst_spacing", cyc - last_cv, 100);
      last_cv = cyc;
      adc_busy = 1'b1;
      adc_data = 12'hA00 + 12'(conv_cnt);
      busy_left = (conv_cnt == stuck_conv) ? 1000000 : busy_len;
      conv_cnt++;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) adc_busy = 1'b0;
    end
  end

  always @(negedge fpga_clk) begin
    if (!sys_rst && win_done) win_cnt++;
  end

  // scoreboard monitor
  always @(negedge fpga_clk) begin
    if (!sys_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_extra: got %h expected none", out_data);
      end else begin
        chk("sb_word", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge fpga_clk);
    #1;
  endtask

  task automatic wait_conv(int n, int budget);
    int k = 0;
    while (conv_cnt < n && k < budget) begin
      @(posedge fpga_clk);
      k++;
    end
    #1;
    chk("wait_conv", 32'(conv_cnt >= n), 1);
  endtask

  task automatic wait_win(int n, int budget);
    int k = 0;
    while (win_cnt < n && k < budget) begin
      @(posedge fpga_clk);
      k++;
    end
    #1;
    chk("wait_win", 32'(win_cnt >= n), 1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  task automatic new_test();
    adc_en = 1'b0;
    tick(5);
    conv_cnt = 0;
    last_cv = -1;
    stuck_conv = -1;
  endtask

  initial begin
    int w0;
    tick(4);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_convst", 32'(adc_convst), 0);
    chk("rst_flags", {29'd0, overflow, timeout, sel_err}, 0);
    chk("rst_data", out_data, 0);
    // level already high at release must not start a window
    adc_en = 1'b1;
    sys_rst = 1'b0;
    tick(300);
    chk("no_edge_conv", 32'(conv_cnt), 0);
    chk("no_edge_win", 32'(win_cnt), 0);

    // 1: full 32-sample window, tags frozen at window start
    new_test();
    w0 = win_cnt;
    rf_sw = 4'b0100;
    rot_count = 10'd5;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back(word(5, 2, i, 12'hA00 + i));
    adc_en = 1'b1;
    tick(200);
    rf_sw = 4'b0001;
    rot_count = 10'd7;
    tick(3800);
    chk("t1_win", 32'(win_cnt - w0), 1);
    chk("t1_convs", 32'(conv_cnt), 32);
    chk("t1_sb_left", 32'(exp_q.size()), 0);
    chk("t1_level", 32'(fifo_level), 0);

    // 2: backpressure overflow then drain
    new_test();
    w0 = win_cnt;
    out_ready = 1'b0;
    rf_sw = 4'b0010;
    rot_count = 10'd9;
    adc_en = 1'b1;
    wait_conv(1, 20);
    tick(1560);
    chk("t2_ovf_pre", 32'(overflow), 0);
    chk("t2_level16", 32'(fifo_level), 16);
    tick(140);
    chk("t2_ovf_set", 32'(overflow), 1);
    tick(250);
    adc_en = 1'b0;
    wait_win(w0 + 1, 200);
    chk("t2_convs", 32'(conv_cnt), 20);
    chk("t2_level", 32'(fifo_level), 16);
    for (int i = 0; i < 16; i++) exp_q.push_back(word(9, 1, i, 12'hA00 + i));
    out_ready = 1'b1;
    tick(30);
    chk("t2_drained", 32'(fifo_level), 0);
    chk("t2_sb_left", 32'(exp_q.size()), 0);
    chk("t2_ovf_hold", 32'(overflow), 1);
    pulse_clr();
    chk("t2_ovf_clr", 32'(overflow), 0);

    // 3: busy stuck on slot 1
    new_test();
    w0 = win_cnt;
    stuck_conv = 1;
    rf_sw = 4'b0001;
    rot_count = 10'd3;
    exp_q.push_back(word(3, 0, 0, 12'hA00));
    exp_q.push_back(word(3, 0, 2, 12'hA02));
    adc_en = 1'b1;
    wait_conv(2, 200);
    tick(60);
    chk("t3_tmo_pre", 32'(timeout), 0);
    tick(10);
    chk("t3_tmo_set", 32'(timeout), 1);
    tick(100);
    adc_en = 1'b0;
    wait_win(w0 + 1, 200);
    chk("t3_convs", 32'(conv_cnt), 3);
    tick(5);
    chk("t3_sb_left", 32'(exp_q.size()), 0);
    pulse_clr();
    chk("t3_tmo_clr", 32'(timeout), 0);

    // 4: non-one-hot select
    new_test();
    w0 = win_cnt;
    rf_sw = 4'b0110;
    adc_en = 1'b1;
    tick(1);
    chk("t4_done", 32'(win_done), 1);
    chk("t4_sel", 32'(sel_err), 1);
    tick(1);
    chk("t4_done_1cyc", 32'(win_done), 0);
    tick(200);
    chk("t4_convs", 32'(conv_cnt), 0);
    chk("t4_wins", 32'(win_cnt - w0), 1);
    pulse_clr();
    chk("t4_sel_clr", 32'(sel_err), 0);

    // 5: adc_en falls during sample 3's conversion
    new_test();
    w0 = win_cnt;
    rf_sw = 4'b1000;
    rot_count = 10'h3FF;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(word(10'h3FF, 3, i, 12'hA00 + i));
    adc_en = 1'b1;
    wait_conv(4, 500);
    adc_en = 1'b0;
    wait_win(w0 + 1, 200);
    tick(200);
    chk("t5_convs", 32'(conv_cnt), 4);
    chk("t5_sb_left", 32'(exp_q.size()), 0);
    chk("t5_wins", 32'(win_cnt - w0), 1);

    // 6: reset during PACE with queued entries
    new_test();
    w0 = win_cnt;
    out_ready = 1'b0;
    rf_sw = 4'b0001;
    adc_en = 1'b1;
    wait_conv(5, 600);
    tick(20);
    chk("t6_level5", 32'(fifo_level), 5);
    sys_rst = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_convst", 32'(adc_convst), 0);
    tick(3);
    sys_rst = 1'b0;
    tick(300);
    chk("t6_no_conv", 32'(conv_cnt), 5);
    chk("t6_no_win", 32'(win_cnt - w0), 0);
    adc_en = 1'b0;
    tick(5);
    chk("end_sb_left", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
